// File: rtl/rv_csr_pkg.sv
// -----------------------------------------------------------------------------
// rv_csr_pkg
// Shared CSR index constants for the machine counter block, plus an index
// decoder used by both the read port and the write port.
//   CSR_*          : 8-bit local CSR indices (lo halves 0x00.., hi halves 0x80..)
//   csr_kind_e     : what a decoded index addresses
//   csr_dec_t      : decoded kind + slot (counter slot or event-select slot)
//   csr_decode()   : maps an index to csr_dec_t for a given counter count
// -----------------------------------------------------------------------------
package rv_csr_pkg;

    localparam logic [7:0] CSR_CYCLE      = 8'h00;
    localparam logic [7:0] CSR_TIME       = 8'h01;
    localparam logic [7:0] CSR_INSTRET    = 8'h02;
    localparam logic [7:0] CSR_HPM_BASE   = 8'h03;
    localparam logic [7:0] CSR_CYCLEH     = 8'h80;
    localparam logic [7:0] CSR_TIMEH      = 8'h81;
    localparam logic [7:0] CSR_INSTRETH   = 8'h82;
    localparam logic [7:0] CSR_HPMH_BASE  = 8'h83;
    localparam logic [7:0] CSR_CNT_LAST   = 8'h9F;
    localparam logic [7:0] CSR_INHIBIT    = 8'h20;
    localparam logic [7:0] CSR_EVSEL_BASE = 8'h23;
    localparam logic [7:0] CSR_OVF        = 8'h40;

    typedef enum logic [2:0] {
        CSR_K_NONE,
        CSR_K_CNT_LO,
        CSR_K_CNT_HI,
        CSR_K_INHIBIT,
        CSR_K_EVSEL,
        CSR_K_OVF
    } csr_kind_e;

    typedef struct packed {
        csr_kind_e  kind;
        logic [7:0] slot;
    } csr_dec_t;

    // Counter slots: 0 = cycle (also time alias), 1 = instret, 2+n = hpm n.
    function automatic csr_dec_t csr_decode(input logic [7:0] idx, input int num_hpm);
        csr_dec_t   d;
        logic [7:0] w_lo7;
        d.kind = CSR_K_NONE;
        d.slot = 8'd0;
        w_lo7  = {1'b0, idx[6:0]};
        if (idx == CSR_INHIBIT) begin
            d.kind = CSR_K_INHIBIT;
        end else if (idx == CSR_OVF) begin
            d.kind = CSR_K_OVF;
        end else if ((int'(idx) >= int'(CSR_EVSEL_BASE)) &&
                     (int'(idx) <  int'(CSR_EVSEL_BASE) + num_hpm)) begin
            d.kind = CSR_K_EVSEL;
            d.slot = idx - CSR_EVSEL_BASE;
        end else if ((idx[7:5] == 3'b000 || idx[7:5] == 3'b100) &&
                     (int'(w_lo7) < int'(CSR_HPM_BASE) + num_hpm)) begin
            d.kind = idx[7] ? CSR_K_CNT_HI : CSR_K_CNT_LO;
            d.slot = (w_lo7 == CSR_CYCLE) ? 8'd0 : (w_lo7 - 8'd1);
        end
        return d;
    endfunction

endpackage

// File: rtl/rv_hpm_counter.sv
// -----------------------------------------------------------------------------
// rv_hpm_counter
// One CNT_W-bit machine counter with half-word load and a sticky wrap flag.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_inc          : count enable for this cycle
//   i_wr_lo/i_wr_hi: load bits [31:0] / [CNT_W-1:32] from i_wr_data
//   i_ovf_clr      : clear the overflow flag (a same-cycle wrap wins)
//   o_count        : current counter value
//   o_overflow     : sticky flag, set when the counter wraps from all-ones
// -----------------------------------------------------------------------------
module rv_hpm_counter #(
    parameter int CNT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_wr_lo,
    input  logic             i_wr_hi,
    input  logic [31:0]      i_wr_data,
    input  logic             i_ovf_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_wr;
    logic             w_wrap;

    // A software load takes the place of the increment, so it can never wrap.
    assign w_wr   = i_wr_lo | i_wr_hi;
    assign w_wrap = i_inc & ~w_wr & (&r_count);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (i_wr_lo) begin
                r_count[31:0] <= i_wr_data;
            end else if (i_wr_hi) begin
                r_count[CNT_W-1:32] <= i_wr_data[CNT_W-33:0];
            end else if (i_inc) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_count    = r_count;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/rv_csr_hpm_counters.sv
// -----------------------------------------------------------------------------
// rv_csr_hpm_counters
// Machine cycle / instret / hpm counters with inhibit, event selects and
// sticky overflow flags, behind a simple 8-bit indexed CSR port.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_instruction_executed  : retire strobe (instret)
//   i_events                : event strobes, selected per hpm counter
//   i_idx / o_data          : read index, registered read data (latency 1)
//   i_wr/i_wr_idx/i_wr_data : write strobe, index, data
//   o_overflow              : bit0 cycle, bit1 instret, bit 2+n hpm n
// -----------------------------------------------------------------------------
module rv_csr_hpm_counters
    import rv_csr_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8,
    parameter int CNT_W      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_instruction_executed,
    input  logic [NUM_EVENTS-1:0] i_events,
    input  logic [7:0]            i_idx,
    output logic [31:0]           o_data,
    input  logic                  i_wr,
    input  logic [7:0]            i_wr_idx,
    input  logic [31:0]           i_wr_data,
    output logic [2+NUM_HPM-1:0]  o_overflow
);

    localparam int NC = 2 + NUM_HPM;
    localparam int IW = 3 + NUM_HPM;
    localparam int NE = (NUM_HPM > 0) ? NUM_HPM : 1;
    // Bit 1 of the inhibit register is the (non-existent) time inhibit.
    localparam logic [IW-1:0] INH_MASK = ~IW'(2'b10);

    logic [CNT_W-1:0] w_cnt [NC];
    logic [NC-1:0]    w_inc;
    logic [NC-1:0]    w_wr_lo;
    logic [NC-1:0]    w_wr_hi;
    logic [NC-1:0]    w_ovf_clr;
    logic [NC-1:0]    w_ovf;
    logic [NE-1:0]    w_ev_hit;
    logic             w_wr_time;
    csr_dec_t         w_rd;
    csr_dec_t         w_wd;
    logic [31:0]      w_rdata;

    logic [IW-1:0]    r_inhibit;
    logic [7:0]       r_evsel [NE];
    logic [31:0]      r_data;

    assign w_rd = csr_decode(i_idx, NUM_HPM);
    assign w_wd = csr_decode(i_wr_idx, NUM_HPM);
    // The time alias is read-only; it decodes to the cycle slot for reads only.
    assign w_wr_time = (i_wr_idx == CSR_TIME) || (i_wr_idx == CSR_TIMEH);

    always_comb begin
        w_wr_lo   = '0;
        w_wr_hi   = '0;
        w_ovf_clr = '0;
        w_ev_hit  = '0;
        w_inc     = '0;
        for (int c = 0; c < NC; c++) begin
            w_wr_lo[c]   = i_wr && !w_wr_time && (w_wd.kind == CSR_K_CNT_LO) && (w_wd.slot == 8'(c));
            w_wr_hi[c]   = i_wr && !w_wr_time && (w_wd.kind == CSR_K_CNT_HI) && (w_wd.slot == 8'(c));
            w_ovf_clr[c] = i_wr && (w_wd.kind == CSR_K_OVF) && i_wr_data[c];
        end
        w_inc[0] = !r_inhibit[0];
        w_inc[1] = i_instruction_executed && !r_inhibit[2];
        for (int n = 0; n < NUM_HPM; n++) begin
            // Select value k counts i_events[k-1]; 0 and out-of-range match nothing.
            for (int k = 1; k <= NUM_EVENTS; k++) begin
                if ((r_evsel[n] == 8'(k)) && i_events[k-1]) begin
                    w_ev_hit[n] = 1'b1;
                end
            end
            w_inc[2+n] = w_ev_hit[n] && !r_inhibit[3+n];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_rd.kind)
            CSR_K_CNT_LO: begin
                for (int c = 0; c < NC; c++) begin
                    if (w_rd.slot == 8'(c)) w_rdata = w_cnt[c][31:0];
                end
            end
            CSR_K_CNT_HI: begin
                for (int c = 0; c < NC; c++) begin
                    if (w_rd.slot == 8'(c)) w_rdata = 32'(w_cnt[c] >> 32);
                end
            end
            CSR_K_INHIBIT: w_rdata = 32'(r_inhibit);
            CSR_K_EVSEL: begin
                for (int n = 0; n < NUM_HPM; n++) begin
                    if (w_rd.slot == 8'(n)) w_rdata = 32'(r_evsel[n]);
                end
            end
            CSR_K_OVF: w_rdata = 32'(w_ovf);
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data    <= '0;
            r_inhibit <= '0;
            for (int n = 0; n < NE; n++) r_evsel[n] <= 8'd0;
        end else begin
            r_data <= w_rdata;
            if (i_wr && (w_wd.kind == CSR_K_INHIBIT)) begin
                r_inhibit <= i_wr_data[IW-1:0] & INH_MASK;
            end
            for (int n = 0; n < NUM_HPM; n++) begin
                if (i_wr && (w_wd.kind == CSR_K_EVSEL) && (w_wd.slot == 8'(n))) begin
                    r_evsel[n] <= i_wr_data[7:0];
                end
            end
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_cnt
        rv_hpm_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_inc      (w_inc[c]),
            .i_wr_lo    (w_wr_lo[c]),
            .i_wr_hi    (w_wr_hi[c]),
            .i_wr_data  (i_wr_data),
            .i_ovf_clr  (w_ovf_clr[c]),
            .o_count    (w_cnt[c]),
            .o_overflow (w_ovf[c])
        );
    end

    assign o_data     = r_data;
    assign o_overflow = w_ovf;

endmodule

// File: tb/tb_rv_csr_hpm_counters.sv
module tb_rv_csr_hpm_counters;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr;
    logic [7:0]  events;
    logic [7:0]  idx;
    logic [31:0] rdata;
    logic        wr;
    logic [7:0]  wr_idx;
    logic [31:0] wr_data;
    logic [5:0]  ovf;

    int n_tests = 0;
    int n_fail  = 0;

    rv_csr_hpm_counters #(
        .NUM_HPM   (4),
        .NUM_EVENTS(8),
        .CNT_W     (64)
    ) dut (
        .i_clk                  (clk),
        .i_reset                (rst),
        .i_instruction_executed (instr),
        .i_events               (events),
        .i_idx                  (idx),
        .o_data                 (rdata),
        .i_wr                   (wr),
        .i_wr_idx               (wr_idx),
        .i_wr_data              (wr_data),
        .o_overflow             (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_csr(input logic [7:0] a, input logic [31:0] d);
        wr = 1'b1; wr_idx = a; wr_data = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_csr(input logic [7:0] a);
        idx = a;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 1'b0; events = '0; idx = 8'h00;
        wr = 1'b0; wr_idx = '0; wr_data = '0;
        tick(); tick();
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", rdata); end
        n_tests++; if (ovf !== 6'd0) begin n_fail++; $display("FAIL reset_ovf: got %0h expected 0", ovf); end
        rst = 1'b0; idx = 8'h00;
        repeat (11) tick();
        n_tests++; if (rdata !== 32'd10) begin n_fail++; $display("FAIL cycle_after_10: got %0d expected 10", rdata); end
        rd_csr(8'h80);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL cycleh_after_10: got %0h expected 0", rdata); end
    endtask

    task automatic test_wrap();
        wr_csr(8'h00, 32'hFFFF_FFFF);
        wr_csr(8'h80, 32'hFFFF_FFFF);
        // Wrap edge coincides with a W1C of the same flag: the flag must stay set.
        wr_csr(8'h40, 32'h1);
        n_tests++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_vs_clear: got %0b expected 1", ovf[0]); end
        idx = 8'h00;
        wr_csr(8'h00, 32'd5);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL cycle_after_wrap: got %0h expected 0", rdata); end
        n_tests++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL write_keeps_ovf: got %0b expected 1", ovf[0]); end
        rd_csr(8'h00);
        n_tests++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL cycle_loaded: got %0d expected 5", rdata); end
        rd_csr(8'h80);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL cycleh_after_wrap: got %0h expected 0", rdata); end
        rd_csr(8'h40);
        n_tests++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL ovf_read: got %0h expected 1", rdata); end
        wr_csr(8'h40, 32'h1);
        n_tests++; if (ovf !== 6'd0) begin n_fail++; $display("FAIL ovf_w1c: got %0h expected 0", ovf); end
    endtask

    task automatic test_hpm();
        wr_csr(8'h23, 32'd3);
        wr_csr(8'h24, 32'd8);
        wr_csr(8'h25, 32'd9);
        wr_csr(8'h26, 32'd0);
        events = 8'h04; repeat (5) tick();
        events = 8'h01; repeat (4) tick();
        events = 8'h00;
        rd_csr(8'h03);
        n_tests++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL hpm0_sel3: got %0d expected 5", rdata); end
        rd_csr(8'h04);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL hpm1_idle: got %0d expected 0", rdata); end
        events = 8'hFF; repeat (2) tick();
        events = 8'h00;
        rd_csr(8'h03);
        n_tests++; if (rdata !== 32'd7) begin n_fail++; $display("FAIL hpm0_ff: got %0d expected 7", rdata); end
        rd_csr(8'h04);
        n_tests++; if (rdata !== 32'd2) begin n_fail++; $display("FAIL hpm1_sel8: got %0d expected 2", rdata); end
        rd_csr(8'h05);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL hpm2_sel9: got %0d expected 0", rdata); end
        rd_csr(8'h06);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL hpm3_sel0: got %0d expected 0", rdata); end
        rd_csr(8'h25);
        n_tests++; if (rdata !== 32'd9) begin n_fail++; $display("FAIL evsel2_read: got %0d expected 9", rdata); end
        wr_csr(8'h03, 32'hFFFF_FFFF);
        wr_csr(8'h83, 32'hFFFF_FFFF);
        events = 8'h04; tick();
        events = 8'h00;
        n_tests++; if (ovf !== 6'b000100) begin n_fail++; $display("FAIL hpm0_wrap_flag: got %b expected 000100", ovf); end
        rd_csr(8'h03);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL hpm0_wrapped_lo: got %0h expected 0", rdata); end
        rd_csr(8'h83);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL hpm0_wrapped_hi: got %0h expected 0", rdata); end
        wr_csr(8'h40, 32'h3F);
        n_tests++; if (ovf !== 6'd0) begin n_fail++; $display("FAIL ovf_clear_all: got %b expected 0", ovf); end
    endtask

    task automatic test_inhibit();
        wr_csr(8'h20, 32'hFFFF_FFFF);
        rd_csr(8'h20);
        n_tests++; if (rdata !== 32'h7D) begin n_fail++; $display("FAIL inhibit_mask: got %0h expected 7d", rdata); end
        wr_csr(8'h20, 32'h5);
        rd_csr(8'h20);
        n_tests++; if (rdata !== 32'h5) begin n_fail++; $display("FAIL inhibit_5: got %0h expected 5", rdata); end
        wr_csr(8'h00, 32'd0);
        wr_csr(8'h80, 32'd0);
        wr_csr(8'h02, 32'd0);
        wr_csr(8'h82, 32'd0);
        instr = 1'b1; repeat (20) tick();
        instr = 1'b0;
        rd_csr(8'h00);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL cycle_inhibited: got %0d expected 0", rdata); end
        rd_csr(8'h02);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL instret_inhibited: got %0d expected 0", rdata); end
        wr_csr(8'h20, 32'h0);
        instr = 1'b1; idx = 8'h02;
        repeat (3) tick();
        instr = 1'b0;
        tick();
        n_tests++; if (rdata !== 32'd3) begin n_fail++; $display("FAIL instret_resume: got %0d expected 3", rdata); end
        rd_csr(8'h00);
        n_tests++; if (rdata !== 32'd4) begin n_fail++; $display("FAIL cycle_resume: got %0d expected 4", rdata); end
    endtask

    task automatic test_instret_write();
        wr = 1'b1; wr_idx = 8'h02; wr_data = 32'd100; instr = 1'b1;
        tick();
        wr = 1'b0; instr = 1'b0; idx = 8'h02;
        tick();
        n_tests++; if (rdata !== 32'd100) begin n_fail++; $display("FAIL instret_write_wins: got %0d expected 100", rdata); end
        instr = 1'b1; tick();
        instr = 1'b0; tick();
        n_tests++; if (rdata !== 32'd101) begin n_fail++; $display("FAIL instret_next_retire: got %0d expected 101", rdata); end
        wr_csr(8'h82, 32'h12);
        rd_csr(8'h82);
        n_tests++; if (rdata !== 32'h12) begin n_fail++; $display("FAIL instreth_write: got %0h expected 12", rdata); end
        rd_csr(8'h02);
        n_tests++; if (rdata !== 32'd101) begin n_fail++; $display("FAIL instret_lo_kept: got %0d expected 101", rdata); end
    endtask

    task automatic test_unmapped();
        wr_csr(8'h20, 32'h1);
        wr_csr(8'h00, 32'd77);
        rd_csr(8'h01);
        n_tests++; if (rdata !== 32'd77) begin n_fail++; $display("FAIL time_alias: got %0d expected 77", rdata); end
        rd_csr(8'h00);
        n_tests++; if (rdata !== 32'd77) begin n_fail++; $display("FAIL cycle_frozen: got %0d expected 77", rdata); end
        rd_csr(8'h81);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL timeh_alias: got %0h expected 0", rdata); end
        wr_csr(8'h07, 32'hDEAD);
        wr_csr(8'h87, 32'hBEEF);
        wr_csr(8'h27, 32'd5);
        rd_csr(8'h07);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_hpm4: got %0h expected 0", rdata); end
        rd_csr(8'h87);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_hpm4h: got %0h expected 0", rdata); end
        rd_csr(8'h27);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_evsel4: got %0h expected 0", rdata); end
        rd_csr(8'h23);
        n_tests++; if (rdata !== 32'd3) begin n_fail++; $display("FAIL evsel0_kept: got %0d expected 3", rdata); end
        rd_csr(8'h06);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL hpm3_kept: got %0h expected 0", rdata); end
        rd_csr(8'hA0);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_a0: got %0h expected 0", rdata); end
    endtask

    task automatic test_reset_midcount();
        wr_csr(8'h20, 32'h0);
        wr_csr(8'h00, 32'hFFFF_FFFF);
        wr_csr(8'h80, 32'hFFFF_FFFF);
        tick();
        n_tests++; if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wrap: got %0b expected 1", ovf[0]); end
        rst = 1'b1; wr = 1'b1; wr_idx = 8'h00; wr_data = 32'd55;
        instr = 1'b1; events = 8'hFF; idx = 8'h23;
        tick();
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midreset_data: got %0h expected 0", rdata); end
        n_tests++; if (ovf !== 6'd0) begin n_fail++; $display("FAIL midreset_ovf: got %b expected 0", ovf); end
        rst = 1'b0; wr = 1'b0; instr = 1'b0; events = 8'h00;
        rd_csr(8'h00);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midreset_cycle: got %0d expected 0", rdata); end
        rd_csr(8'h02);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midreset_instret: got %0d expected 0", rdata); end
        rd_csr(8'h23);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midreset_evsel: got %0d expected 0", rdata); end
        rd_csr(8'h03);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midreset_hpm0: got %0d expected 0", rdata); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_hpm();
        test_inhibit();
        test_instret_write();
        test_unmapped();
        test_reset_midcount();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
